// File: rtl/wm_phase_timer.sv
// -----------------------------------------------------------------------------
// wm_phase_timer
//
// Times the SOAK / WASH / RINSE / SPIN phases of the washing-machine
// controller. A change of the controller state is detected by comparing it
// against a registered copy (prev_state). Entering a timed phase loads that
// phase's duration. A prescaler divides the clock into timer ticks, and the
// remaining count drops by one on each tick. When the count reaches zero a
// single-cycle sig_Time_Out pulse is sent back to the controller.
//
// Optional feature:
//   WM_TIMER_PAUSE_EN - when defined, an open lid (sig_Lid_Closed=0) freezes
//                       the prescaler and the remaining count of a running
//                       phase. When undefined, sig_Lid_Closed is ignored.
//
// Parameters:
//   PRESCALE     clock cycles per timer tick (1..65535)
//   SOAK_TICKS   SOAK  duration in ticks (8-bit)
//   WASH_TICKS   WASH  duration in ticks (8-bit)
//   RINSE_TICKS  RINSE duration in ticks (8-bit)
//   SPIN_TICKS   SPIN  duration in ticks (8-bit)
//
// Ports:
//   clock           in   system clock; all state changes on the rising edge
//   reset           in   synchronous, active-high reset
//   state[2:0]      in   controller state: 2=SOAK 3=WASH 4=RINSE 5=SPIN,
//                        every other value is untimed
//   sig_Lid_Closed  in   lid sensor, 1=closed (used only with pause enabled)
//   sig_Time_Out    out  registered one-cycle pulse when a timed phase expires
//   remaining[7:0]  out  registered ticks left in the current phase
//   active          out  registered, 1 while remaining is non-zero
// -----------------------------------------------------------------------------
module wm_phase_timer #(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned SOAK_TICKS  = 8,
    parameter int unsigned WASH_TICKS  = 16,
    parameter int unsigned RINSE_TICKS = 8,
    parameter int unsigned SPIN_TICKS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       sig_Lid_Closed,
    output logic       sig_Time_Out,
    output logic [7:0] remaining,
    output logic       active
);

    // Controller state codes that carry a duration.
    typedef enum logic [2:0] {
        PH_SOAK  = 3'd2,
        PH_WASH  = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  SOAK_LOAD     = 8'(SOAK_TICKS);
    localparam logic [7:0]  WASH_LOAD     = 8'(WASH_TICKS);
    localparam logic [7:0]  RINSE_LOAD    = 8'(RINSE_TICKS);
    localparam logic [7:0]  SPIN_LOAD     = 8'(SPIN_TICKS);

    logic [2:0]  prev_state;
    logic [15:0] prescaler;

    logic        phase_entry;
    logic        timed;
    logic [7:0]  load_ticks;
    logic        run;

    logic [15:0] nxt_prescaler;
    logic [7:0]  nxt_remaining;
    logic        nxt_time_out;

    // Counting is allowed only while the lid is closed when pausing is built
    // in; otherwise the lid input has no effect at all.
`ifdef WM_TIMER_PAUSE_EN
    assign run = sig_Lid_Closed;
`else
    logic unused_lid;
    assign unused_lid = sig_Lid_Closed;
    assign run        = 1'b1;
`endif

    assign phase_entry = (state != prev_state);

    // Duration lookup for the incoming controller state.
    always_comb begin
        timed      = 1'b0;
        load_ticks = '0;
        case (state)
            PH_SOAK: begin
                timed      = 1'b1;
                load_ticks = SOAK_LOAD;
            end
            PH_WASH: begin
                timed      = 1'b1;
                load_ticks = WASH_LOAD;
            end
            PH_RINSE: begin
                timed      = 1'b1;
                load_ticks = RINSE_LOAD;
            end
            PH_SPIN: begin
                timed      = 1'b1;
                load_ticks = SPIN_LOAD;
            end
            default: begin
                timed      = 1'b0;
                load_ticks = '0;
            end
        endcase
    end

    // Next-value logic. Phase entry has priority over a tick on the same
    // edge, so a phase change at remaining=1 reloads without pulsing.
    always_comb begin
        nxt_prescaler = prescaler;
        nxt_remaining = remaining;
        nxt_time_out  = 1'b0;

        if (phase_entry) begin
            nxt_prescaler = '0;
            if (timed) begin
                nxt_remaining = load_ticks;
                // A zero-length phase expires immediately on entry.
                nxt_time_out  = (load_ticks == 8'd0);
            end else begin
                nxt_remaining = '0;
            end
        end else if ((remaining != 8'd0) && run) begin
            if (prescaler == PRESCALE_LAST) begin
                nxt_prescaler = '0;
                nxt_remaining = remaining - 8'd1;
                nxt_time_out  = (remaining == 8'd1);
            end else begin
                nxt_prescaler = prescaler + 16'd1;
            end
        end
    end

    // Clearing prev_state on reset makes a timed state that was held across
    // reset look like a fresh entry on the first edge after release.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_state   <= '0;
            prescaler    <= '0;
            remaining    <= '0;
            sig_Time_Out <= 1'b0;
            active       <= 1'b0;
        end else begin
            prev_state   <= state;
            prescaler    <= nxt_prescaler;
            remaining    <= nxt_remaining;
            sig_Time_Out <= nxt_time_out;
            active       <= (nxt_remaining != 8'd0);
        end
    end

endmodule

// File: tb/tb_wm_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_wm_phase_timer
//
// Drives two timers (PRESCALE=1 and PRESCALE=4, SOAK=3 WASH=5 RINSE=2 SPIN=0)
// from the same stimulus. A reference model keeps, for each timer, the
// duration of the current phase and the number of counting cycles spent in
// it. It derives remaining = duration - cycles/PRESCALE and flags expiry when
// cycles reaches duration*PRESCALE.
// -----------------------------------------------------------------------------
module tb_wm_phase_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic       lid;

    logic       to1, act1, to4, act4;
    logic [7:0] rem1, rem4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    wm_phase_timer #(
        .PRESCALE   (1),
        .SOAK_TICKS (3),
        .WASH_TICKS (5),
        .RINSE_TICKS(2),
        .SPIN_TICKS (0)
    ) dut1 (
        .clock         (clock),
        .reset         (reset),
        .state         (state),
        .sig_Lid_Closed(lid),
        .sig_Time_Out  (to1),
        .remaining     (rem1),
        .active        (act1)
    );

    wm_phase_timer #(
        .PRESCALE   (4),
        .SOAK_TICKS (3),
        .WASH_TICKS (5),
        .RINSE_TICKS(2),
        .SPIN_TICKS (0)
    ) dut4 (
        .clock         (clock),
        .reset         (reset),
        .state         (state),
        .sig_Lid_Closed(lid),
        .sig_Time_Out  (to4),
        .remaining     (rem4),
        .active        (act4)
    );

    // ---------------- reference model ----------------
    int ps     [2] = '{1, 4};
    int m_prev [2];
    int m_dur  [2];
    int m_cnt  [2];
    bit m_pulse[2];

    function automatic int dur_of(input int s);
        case (s)
            2: return 3;
            3: return 5;
            4: return 2;
            5: return 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_timed(input int s);
        return (s >= 2) && (s <= 5);
    endfunction

    function automatic int m_rem(input int i);
        return m_dur[i] - (m_cnt[i] / ps[i]);
    endfunction

    function automatic bit lid_ok();
`ifdef WM_TIMER_PAUSE_EN
        return lid;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_prev[i]  = 0;
                m_dur[i]   = 0;
                m_cnt[i]   = 0;
                m_pulse[i] = 1'b0;
            end else if (int'(state) != m_prev[i]) begin
                m_prev[i]  = int'(state);
                m_dur[i]   = dur_of(int'(state));
                m_cnt[i]   = 0;
                m_pulse[i] = is_timed(int'(state)) && (m_dur[i] == 0);
            end else if ((m_rem(i) > 0) && lid_ok()) begin
                m_cnt[i]   = m_cnt[i] + 1;
                m_pulse[i] = (m_cnt[i] == m_dur[i] * ps[i]);
            end else begin
                m_pulse[i] = 1'b0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s @cyc%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output of both timers 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        chk("rem_p1",    16'(rem1), 16'(m_rem(0)));
        chk("to_p1",     16'(to1),  16'(m_pulse[0]));
        chk("active_p1", 16'(act1), 16'(m_rem(0) != 0));
        chk("rem_p4",    16'(rem4), 16'(m_rem(1)));
        chk("to_p4",     16'(to4),  16'(m_pulse[1]));
        chk("active_p4", 16'(act4), 16'(m_rem(1) != 0));
    endtask

    int pulses;
    int pulse_at;
    int hold_len;

    initial begin
        reset = 1'b1;
        state = 3'd0;
        lid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 0; m_dur[i] = 0; m_cnt[i] = 0; m_pulse[i] = 1'b0;
        end

        // Reset state
        step();
        step();
        chk("reset_rem", 16'(rem1), 16'd0);
        chk("reset_to",  16'(to1),  16'd0);

        // WASH from edge 1: 5,4,3,2,1,0 with a pulse only after edge 6
        reset = 1'b0;
        state = 3'd3;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("wash_seq_rem", 16'(rem1), 16'(6 - k));
            chk("wash_seq_to",  16'(to1),  16'(k == 6));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (to1) pulses++;
        end
        chk("wash_no_repulse", 16'(pulses), 16'd0);

        // SOAK with PRESCALE=4: one pulse, 12 cycles after the entry edge
        state = 3'd2;
        pulses = 0;
        pulse_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (to4) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("p4_pulse_cnt", 16'(pulses),   16'd1);
        chk("p4_pulse_at",  16'(pulse_at), 16'd13);

        // RINSE, switch to WASH at remaining=1: reload wins, no pulse
        state = 3'd4;
        step();
        step();
        chk("rinse_at_1", 16'(rem1), 16'd1);
        state = 3'd3;
        step();
        chk("switch_rem", 16'(rem1), 16'd5);
        chk("switch_to",  16'(to1),  16'd0);

        // SPIN with zero ticks pulses on entry; untimed state clears
        state = 3'd5;
        step();
        chk("spin_to",  16'(to1),  16'd1);
        chk("spin_rem", 16'(rem1), 16'd0);
        step();
        chk("spin_once", 16'(to1), 16'd0);
        state = 3'd1;
        step();
        chk("untimed_rem", 16'(rem1), 16'd0);

        // Reset mid-WASH at remaining=2 with state held, then reload
        state = 3'd3;
        for (int k = 0; k < 4; k++) step();
        chk("pre_reset_rem", 16'(rem1), 16'd2);
        reset = 1'b1;
        step();
        chk("in_reset_rem", 16'(rem1), 16'd0);
        chk("in_reset_act", 16'(act1), 16'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_reset_rem", 16'(rem1), 16'd5);

        // Lid open for 3 cycles at remaining=3
        state = 3'd0;
        step();
        state = 3'd3;
        for (int k = 0; k < 3; k++) step();
        chk("lid_pre_rem", 16'(rem1), 16'd3);
        lid = 1'b0;
        for (int k = 0; k < 3; k++) step();
`ifdef WM_TIMER_PAUSE_EN
        chk("lid_hold_rem", 16'(rem1), 16'd3);
`else
        chk("lid_hold_rem", 16'(rem1), 16'd0);
`endif
        lid = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Randomized phases, lid activity and occasional reset
        for (int n = 0; n < 60; n++) begin
            state    = 3'($urandom_range(0, 7));
            reset    = ($urandom_range(0, 19) == 0);
            hold_len = $urandom_range(1, 24);
            for (int k = 0; k < hold_len; k++) begin
                lid = ($urandom_range(0, 4) != 0);
                step();
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
